run_len_detector: RTL and testbench
===================================

Name: run_len_detector

Overview:
- Parametrised run-length detector; the next generation of the team's fixed 4-in-a-row serial pattern FSM.
- Samples a serial bit `w` on qualified cycles and flags a run of RUN_LEN identical consecutive bits, either 0s or 1s.
- Reports which value formed the run and keeps a saturating count of detections.
- Two modes: sticky, where `out` stays high while the run continues; and non-overlapping, a one-cycle pulse after which the run restarts.

Parameters:
RUN_LEN  4  run length to detect; legal range >= 2.
CNT_W    8  width of the detection event counter.

Ports:
clk       input   1                         rising-edge clock
rst       input   1                         asynchronous reset, active-high
en        input   1                         sample qualifier; `w` is consumed only when en=1
w         input   1                         serial data bit
mode      input   1                         0 = sticky/overlapping, 1 = non-overlapping pulse
clr       input   1                         synchronous clear of evt_cnt
out       output  1                         run detected (registered)
out_val   output  1                         bit value of the detected run (valid while out=1)
det_pulse output  1                         one-cycle pulse per new detection
run_cnt   output  $clog2(RUN_LEN+1)         current run length, saturating at RUN_LEN
evt_cnt   output  CNT_W                     saturating detection count

Behaviour:
- Reset (rst=1, async, any time): state=IDLE, run_cnt=0, out=0, out_val=0, det_pulse=0, evt_cnt=0, mode_q=mode.
- States: IDLE (no bit seen), ZEROS (current run is 0s), ONES (current run is 1s). All outputs are registered; no combinational path from input to output.
- en=0 cycle:
  - state, run_cnt and out_val hold.
  - det_pulse=0.
  - Mode 0: out holds. Mode 1: out=0.
- en=1, state IDLE: go to ZEROS if w=0, ONES if w=1; run_cnt=1.
- en=1, w differs from the current run value: switch to the other run state; run_cnt=1; out=0.
- en=1, w equals the current run value, mode 0:
  - run_cnt = min(run_cnt+1, RUN_LEN).
  - When run_cnt becomes RUN_LEN from RUN_LEN-1: out=1, out_val=w, det_pulse=1.
  - Further equal bits keep out=1 with det_pulse=0.
- en=1, w equals the current run value, mode 1:
  - If run_cnt+1 == RUN_LEN: det_pulse=1, out=1 for that one cycle, out_val=w, run_cnt=0, state unchanged. The next equal bit gives run_cnt=1.
  - Otherwise run_cnt increments and out=0.
- Latency: out and det_pulse are high in the cycle after the edge that samples the RUN_LEN-th bit. Example, RUN_LEN=4: a bit sampled at edges 1..4 makes out high after edge 4.
- Mode change: mode is registered into mode_q every cycle. If mode != mode_q on an edge, that edge forces IDLE, run_cnt=0, out=0 and det_pulse=0; the w sample is discarded even if en=1.
- evt_cnt:
  - Increments on every det_pulse.
  - Saturates at 2^CNT_W-1, no wrap.
  - clr=1 sets evt_cnt to 0 and wins over a simultaneous detection (that detection is not counted). det_pulse and out are unaffected by clr.
- run_cnt never exceeds RUN_LEN.
- out_val retains its last value when out=0.

Test Plan (RUN_LEN=4, CNT_W=4):
1. Reset then mode=0, en=1, w=0,0,0,0,0,1 → out=0 for 3 cycles, then out=1 after the 4th 0, out_val=0, det_pulse once, out stays 1 after the 5th 0, out=0 after the 1; evt_cnt=1.
2. mode=1, en=1, w=1 ×9 → det_pulse and out high after the 4th and 8th 1 only; run_cnt after the 9th bit=1; evt_cnt=2.
3. mode=0, w=1,1,1 with en=0 on two interleaved cycles, then a 4th 1 → out rises only after the 4th qualified 1; run_cnt holds across en=0.
4. mode=0, alternating w=0,1,0,1,… for 20 cycles → out never rises; run_cnt stays 1; evt_cnt=0.
5. Saturation/clear: 20 non-overlapping detections in mode 1 → evt_cnt=15. Then clr=1 coincident with a detection → evt_cnt=0 and det_pulse=1.
6. Mid-run disturbances:
   - Toggle mode while run_cnt=3 → IDLE, run_cnt=0; the next 3 equal bits do not detect.
   - Assert rst asynchronously while out=1 → all outputs 0 immediately.

Source files
------------

// File: rtl/run_len_detector.sv
// Serial run-length detector: flags RUN_LEN identical consecutive qualified bits
// in sticky (mode=0) or non-overlapping pulse (mode=1) form, with a saturating event count.
module run_len_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         w,
  input  logic                         mode,
  input  logic                         clr,
  output logic                         out,
  output logic                         out_val,
  output logic                         det_pulse,
  output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
  output logic [CNT_W-1:0]             evt_cnt
);

  localparam int RC_W = $clog2(RUN_LEN + 1);
  localparam logic [RC_W-1:0]  RUN_MAX = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0]  RUN_PRE = RC_W'(RUN_LEN - 1);
  localparam logic [RC_W-1:0]  RUN_ONE = RC_W'(1);
  localparam logic [CNT_W-1:0] EVT_MAX = '1;
  localparam logic [CNT_W-1:0] EVT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    ONES  = 2'd2
  } state_t;

  state_t           state_q;
  logic             mode_q;
  logic             out_q;
  logic             out_val_q;
  logic             det_q;
  logic [RC_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0] evt_cnt_q;

  logic mode_chg;
  logic same_bit;
  logic det_d;

  // A detection is the qualified bit that extends a RUN_LEN-1 run; same test in both modes.
  always_comb begin
    mode_chg = (mode != mode_q);
    same_bit = 1'b0;
    if (state_q == ONES)
      same_bit = w;
    else if (state_q == ZEROS)
      same_bit = ~w;
    det_d = ~mode_chg & en & same_bit & (run_cnt_q == RUN_PRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= mode;
      run_cnt_q <= '0;
      out_q     <= 1'b0;
      out_val_q <= 1'b0;
      det_q     <= 1'b0;
    end else begin
      mode_q <= mode;
      det_q  <= det_d;
      if (mode_chg) begin
        // The sample on a mode-switch edge is discarded and the run restarts.
        state_q   <= IDLE;
        run_cnt_q <= '0;
        out_q     <= 1'b0;
      end else if (!en) begin
        if (mode)
          out_q <= 1'b0;
      end else if (!same_bit) begin
        state_q   <= w ? ONES : ZEROS;
        run_cnt_q <= RUN_ONE;
        out_q     <= 1'b0;
      end else if (det_d) begin
        out_q     <= 1'b1;
        out_val_q <= w;
        run_cnt_q <= mode ? '0 : RUN_MAX;
      end else if (run_cnt_q == RUN_MAX) begin
        out_q <= 1'b1;
      end else begin
        run_cnt_q <= run_cnt_q + RUN_ONE;
        out_q     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      evt_cnt_q <= '0;
    else if (clr)
      evt_cnt_q <= '0;
    else if (det_d && evt_cnt_q != EVT_MAX)
      evt_cnt_q <= evt_cnt_q + EVT_ONE;
  end

  assign out       = out_q;
  assign out_val   = out_val_q;
  assign det_pulse = det_q;
  assign run_cnt   = run_cnt_q;
  assign evt_cnt   = evt_cnt_q;

endmodule

// File: tb/tb_run_len_detector.sv
// Randomized and directed bench for run_len_detector against a queue-based model
// that tracks the qualified bit history since the last run restart.
module tb_run_len_detector;

  localparam int RL  = 4;
  localparam int CW  = 4;
  localparam int RCW = $clog2(RL + 1);
  localparam int VW  = 3 + RCW + CW;
  localparam int EVT_SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, en, w, mode, clr;
  logic out, out_val, det_pulse;
  logic [RCW-1:0] run_cnt;
  logic [CW-1:0]  evt_cnt;

  run_len_detector #(.RUN_LEN(RL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .w(w), .mode(mode), .clr(clr),
    .out(out), .out_val(out_val), .det_pulse(det_pulse),
    .run_cnt(run_cnt), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: qualified bits since the run last restarted.
  bit hist[$];
  bit m_out, m_val, m_det, m_prev_mode;
  int m_evt;

  function automatic int trailing();
    int n;
    n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int m_run();
    int t;
    t = trailing();
    return (t > RL) ? RL : t;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_out = 0; m_val = 0; m_det = 0; m_evt = 0;
    m_prev_mode = mode;
  endtask

  // Applies one cycle of inputs, advances the model, returns observed and predicted vectors.
  task automatic drive(input bit e, input bit b, input bit md, input bit c,
                       output logic [VW-1:0] got, output logic [VW-1:0] exp_v);
    int t;
    en = e; w = b; mode = md; clr = c;
    @(posedge clk);
    #1;
    m_det = 0;
    if (md != m_prev_mode) begin
      hist.delete();
      m_out = 0;
    end else if (!e) begin
      if (md) m_out = 0;
    end else begin
      hist.push_back(b);
      if (hist.size() > RL + 1) void'(hist.pop_front());
      t = trailing();
      if (t == RL) begin
        m_det = 1; m_out = 1; m_val = b;
        if (md) hist.delete();
      end else begin
        m_out = (!md && t > RL);
      end
    end
    m_prev_mode = md;
    if (c) m_evt = 0;
    else if (m_det && m_evt < EVT_SAT) m_evt++;
    got   = {out, out_val, det_pulse, run_cnt, evt_cnt};
    exp_v = {m_out, m_val, m_det, RCW'(m_run()), CW'(m_evt)};
    $display("tx en=%0b w=%0b mode=%0b clr=%0b -> out=%0b val=%0b det=%0b run=%0d evt=%0d",
             e, b, md, c, out, out_val, det_pulse, run_cnt, evt_cnt);
  endtask

  task automatic test_reset();
    rst = 1; en = 0; w = 0; mode = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out, out_val, det_pulse, run_cnt, evt_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {out, out_val, det_pulse, run_cnt, evt_cnt});
    end
    rst = 0;
    model_reset();
  endtask

  task automatic test_sticky_run();
    logic [VW-1:0] got, exp_v;
    bit ex_out[6] = '{0, 0, 0, 1, 1, 0};
    bit ex_det[6] = '{0, 0, 0, 1, 0, 0};
    bit bits[6]   = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1, bits[i], 0, 0, got, exp_v);
      total++;
      if (got !== exp_v) begin
        bad++; $display("FAIL sticky_model step=%0d got=%h exp=%h", i, got, exp_v);
      end
      total++;
      if (out !== ex_out[i] || det_pulse !== ex_det[i] || (ex_out[i] && out_val !== 1'b0)) begin
        bad++;
        $display("FAIL sticky_table step=%0d got out=%0b det=%0b val=%0b exp out=%0b det=%0b",
                 i, out, det_pulse, out_val, ex_out[i], ex_det[i]);
      end
    end
    total++;
    if (evt_cnt !== CW'(1)) begin
      bad++; $display("FAIL sticky_evt got=%0d exp=1", evt_cnt);
    end
  endtask

  task automatic test_pulse_mode();
    logic [VW-1:0] got, exp_v;
    drive(0, 0, 1, 1, got, exp_v);
    total++;
    if (got !== exp_v) begin
      bad++; $display("FAIL pulse_switch got=%h exp=%h", got, exp_v);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 1, 0, got, exp_v);
      total++;
      if (got !== exp_v || det_pulse !== (i == 3 || i == 7) || out !== (i == 3 || i == 7)) begin
        bad++; $display("FAIL pulse_model step=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    total++;
    if (run_cnt !== RCW'(1) || evt_cnt !== CW'(2)) begin
      bad++; $display("FAIL pulse_end got run=%0d evt=%0d exp run=1 evt=2", run_cnt, evt_cnt);
    end
  endtask

  task automatic test_en_gaps();
    logic [VW-1:0] got, exp_v;
    bit ens[6]   = '{1, 0, 1, 0, 1, 1};
    int ex_run[6] = '{1, 1, 2, 2, 3, 4};
    drive(0, 0, 0, 1, got, exp_v);
    for (int i = 0; i < 6; i++) begin
      drive(ens[i], 1, 0, 0, got, exp_v);
      total++;
      if (got !== exp_v || run_cnt !== RCW'(ex_run[i]) || out !== (i == 5)) begin
        bad++;
        $display("FAIL en_gap step=%0d got=%h exp=%h run=%0d exp_run=%0d", i, got, exp_v, run_cnt,
                 ex_run[i]);
      end
    end
  endtask

  task automatic test_alternating();
    logic [VW-1:0] got, exp_v;
    int rises;
    rises = 0;
    drive(0, 0, 0, 1, got, exp_v);
    for (int i = 0; i < 20; i++) begin
      drive(1, i[0], 0, 0, got, exp_v);
      if (out) rises++;
      total++;
      if (got !== exp_v || run_cnt !== RCW'(1)) begin
        bad++; $display("FAIL alternate step=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    total++;
    if (rises != 0 || evt_cnt !== '0) begin
      bad++; $display("FAIL alternate_end got rises=%0d evt=%0d exp 0 0", rises, evt_cnt);
    end
  endtask

  task automatic test_saturate_clear();
    logic [VW-1:0] got, exp_v;
    int dets;
    dets = 0;
    drive(0, 0, 1, 1, got, exp_v);
    for (int i = 0; i < 4 * 20; i++) begin
      drive(1, 1, 1, 0, got, exp_v);
      if (det_pulse) dets++;
      total++;
      if (got !== exp_v) begin
        bad++; $display("FAIL saturate step=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    total++;
    if (dets != 20 || evt_cnt !== CW'(EVT_SAT)) begin
      bad++; $display("FAIL saturate_end got dets=%0d evt=%0d exp 20 %0d", dets, evt_cnt, EVT_SAT);
    end
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, got, exp_v);
    drive(1, 1, 1, 1, got, exp_v);
    total++;
    if (got !== exp_v || det_pulse !== 1'b1 || evt_cnt !== '0) begin
      bad++;
      $display("FAIL clear_vs_det got det=%0b evt=%0d exp det=1 evt=0", det_pulse, evt_cnt);
    end
  endtask

  task automatic test_disturb();
    logic [VW-1:0] got, exp_v;
    drive(0, 0, 0, 0, got, exp_v);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, got, exp_v);
    total++;
    if (got !== exp_v || run_cnt !== RCW'(3)) begin
      bad++; $display("FAIL disturb_pre got run=%0d exp=3", run_cnt);
    end
    drive(1, 0, 1, 0, got, exp_v);
    total++;
    if (got !== exp_v || run_cnt !== '0 || out !== 1'b0) begin
      bad++; $display("FAIL mode_toggle got run=%0d out=%0b exp run=0 out=0", run_cnt, out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, got, exp_v);
      total++;
      if (got !== exp_v || det_pulse !== 1'b0 || run_cnt !== RCW'(i + 1)) begin
        bad++; $display("FAIL after_toggle step=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    drive(0, 0, 0, 0, got, exp_v);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, got, exp_v);
    total++;
    if (got !== exp_v || out !== 1'b1 || out_val !== 1'b1) begin
      bad++; $display("FAIL pre_async got out=%0b val=%0b exp 1 1", out, out_val);
    end
    #3 rst = 1;
    #1;
    total++;
    if ({out, out_val, det_pulse, run_cnt, evt_cnt} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {out, out_val, det_pulse, run_cnt, evt_cnt});
    end
    model_reset();
    #2 rst = 0;
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp_v;
    bit b, md, e, c;
    b = 0; md = mode;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) b = ~b;
      if ($urandom_range(39) == 0) md = ~md;
      e = ($urandom_range(3) != 0);
      c = ($urandom_range(24) == 0);
      drive(e, b, md, c, got, exp_v);
      total++;
      if (got !== exp_v) begin
        bad++; $display("FAIL random step=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sticky_run();
    test_pulse_mode();
    test_en_gaps();
    test_alternating();
    test_saturate_clear();
    test_disturb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
